// File: rtl/rom_rd_pkg.sv
// Shared types and default widths for the ROM burst reader.
// Holds the FSM state enum and the checksum width.
package rom_rd_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int ADDR_WIDTH  = 10;
    localparam int CKSUM_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/rom_rd_fifo.sv
// Synchronous FIFO buffering ROM words for the output stream.
// Ports: push/din, pop/dout, full/empty/count, flush (clears all).
module rom_rd_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import rom_rd_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when a pop frees a slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push)
                           - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read initiator for the single-port ROM macro: issues cs/addr,
// captures dout after READ_LATENCY, streams bytes out, sums a checksum.
// Ports: start/base_addr/length/abort command, busy/done/checksum status,
// rom_cs/rom_addr/rom_dout ROM side, m_data/m_valid/m_ready stream side.
module rom_burst_reader
#(
    parameter int DATA_WIDTH   = rom_rd_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = rom_rd_pkg::ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [ADDR_WIDTH:0]                length,
    input  logic                               abort,
    output logic                               busy,
    output logic                               done,
    output logic [rom_rd_pkg::CKSUM_WIDTH-1:0] checksum,
    output logic                               rom_cs,
    output logic [ADDR_WIDTH-1:0]              rom_addr,
    input  logic [DATA_WIDTH-1:0]              rom_dout,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic                               m_valid,
    input  logic                               m_ready
);
    import rom_rd_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic [ADDR_WIDTH:0]     issue_left;
    logic [ADDR_WIDTH:0]     accept_left;
    logic [READ_LATENCY-1:0] tag;
    logic [CW-1:0]           fifo_count;
    logic [DATA_WIDTH-1:0]   fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    accept;
    logic                    flush;
    logic                    credit;

    assign flush   = abort && (state != IDLE);
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_dout;
    assign accept  = m_valid && m_ready;

    // Every word already issued (cs high now or tagged in the
    // latency pipe) owns a FIFO slot, so the FIFO cannot overflow.
    assign credit = !fifo_full
        && (32'(fifo_count) + 32'($countones(tag))
            + 32'(rom_cs)) < 32'(FIFO_DEPTH);

    rom_rd_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (tag[READ_LATENCY-1]),
        .din   (rom_dout),
        .pop   (accept),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            checksum    <= '0;
            rom_cs      <= 1'b0;
            rom_addr    <= '0;
            nxt_addr    <= '0;
            issue_left  <= '0;
            accept_left <= '0;
            tag         <= '0;
        end else begin
            done   <= 1'b0;
            rom_cs <= 1'b0;
            // Tag follows each issued read until its dout is valid.
            tag    <= (tag << 1) | READ_LATENCY'(rom_cs);
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
                tag   <= '0;
            end else begin
                if (accept) begin
                    checksum    <= checksum
                                 + CKSUM_WIDTH'(m_data);
                    accept_left <= accept_left - 1'b1;
                end
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            checksum <= '0;
                            if (length == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state       <= ISSUE;
                                busy        <= 1'b1;
                                nxt_addr    <= base_addr;
                                issue_left  <= length;
                                accept_left <= length;
                            end
                        end
                    end
                    ISSUE: begin
                        if (credit) begin
                            rom_cs     <= 1'b1;
                            rom_addr   <= nxt_addr;
                            nxt_addr   <= nxt_addr + 1'b1;
                            issue_left <= issue_left - 1'b1;
                            if (issue_left == (ADDR_WIDTH+1)'(1))
                                state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (accept && accept_left
                                == (ADDR_WIDTH+1)'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
